// File: rtl/branch_predictor_bimodal_ras.sv
// Fetch-stage predictor: direct-mapped BTB, bimodal/gshare saturating-counter PHT and a circular RAS.
// Lookup is combinational on i_pc_f; resolved control flow from ID updates state one entry per cycle.
module branch_predictor_bimodal_ras #(
   parameter int BTB_ENTRIES = 64,
   parameter int PHT_ENTRIES = 256,
   parameter int CNT_BITS    = 2,
   parameter int HIST_BITS   = 0,
   parameter int RAS_DEPTH   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc_f,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_target,
   input  logic [31:0] i_pc_d,
   input  logic        i_cflow_valid,
   input  logic        i_cflow_taken,
   input  logic [31:0] i_cflow_target,
   input  logic        i_cflow_is_branch,
   input  logic        i_cflow_is_call,
   input  logic        i_cflow_is_ret
);
   localparam int IDX  = $clog2(BTB_ENTRIES);
   localparam int PIDX = $clog2(PHT_ENTRIES);
   localparam int TAGW = 30 - IDX;
   localparam int GHW  = (HIST_BITS > 0) ? HIST_BITS : 1;
   localparam int RPW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RCW  = $clog2(RAS_DEPTH + 1);

   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   localparam logic [RPW-1:0]      RAS_LAST = RPW'(RAS_DEPTH - 1);
   localparam logic [RCW-1:0]      RAS_FULL = RCW'(RAS_DEPTH);

   typedef enum logic [1:0] {BT_BR, BT_JMP, BT_RET} btb_type_e;

   logic [BTB_ENTRIES-1:0] r_btb_valid;
   logic [TAGW-1:0]        r_btb_tag    [BTB_ENTRIES];
   logic [29:0]            r_btb_target [BTB_ENTRIES];
   btb_type_e              r_btb_type   [BTB_ENTRIES];
   logic [CNT_BITS-1:0]    r_pht        [PHT_ENTRIES];
   logic [GHW-1:0]         r_ghr;
   logic [31:0]            r_ras        [RAS_DEPTH];
   logic [RPW-1:0]         r_ras_ptr;   // next free slot; top entry sits one below
   logic [RCW-1:0]         r_ras_cnt;

   // History is left-aligned in the index; with HIST_BITS == 0 the shift clears it entirely.
   logic [PIDX-1:0] w_hist;
   assign w_hist = PIDX'(r_ghr) << (PIDX - HIST_BITS);

   logic [IDX-1:0]  w_f_idx, w_d_idx;
   logic [PIDX-1:0] w_f_pidx, w_d_pidx;
   logic            w_f_hit;
   btb_type_e       w_f_type;
   logic [RPW-1:0]  w_ras_top, w_ras_next, w_ras_wr;
   logic            w_upd;

   assign w_f_idx    = i_pc_f[IDX+1:2];
   assign w_d_idx    = i_pc_d[IDX+1:2];
   assign w_f_pidx   = i_pc_f[PIDX+1:2] ^ w_hist;
   assign w_d_pidx   = i_pc_d[PIDX+1:2] ^ w_hist;
   assign w_f_hit    = r_btb_valid[w_f_idx] && (r_btb_tag[w_f_idx] == i_pc_f[31:IDX+2]);
   assign w_f_type   = r_btb_type[w_f_idx];
   assign w_ras_top  = (r_ras_ptr == '0) ? RAS_LAST : r_ras_ptr - RPW'(1);
   assign w_ras_next = (r_ras_ptr == RAS_LAST) ? '0 : r_ras_ptr + RPW'(1);
   assign w_ras_wr   = (i_cflow_is_ret && r_ras_cnt != '0) ? w_ras_top : r_ras_ptr;
   assign w_upd      = i_cflow_valid && !i_rst;

   // NOTE: every output gets a default before the if, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      o_pred_taken  = 1'b0;
      o_pred_target = i_pc_f + 32'd4;
      if (!i_rst && w_f_hit && (w_f_type != BT_BR || r_pht[w_f_pidx][CNT_BITS-1])) begin
         o_pred_taken = 1'b1;
         if (w_f_type == BT_RET && r_ras_cnt != '0)
            o_pred_target = r_ras[w_ras_top];
         else
            o_pred_target = {r_btb_target[w_f_idx], 2'b00};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every read in this block sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_btb_valid <= '0;
         for (int i = 0; i < PHT_ENTRIES; i++)
            r_pht[i] <= CNT_INIT;
         r_ghr     <= '0;
         r_ras_ptr <= '0;
         r_ras_cnt <= '0;
      end else if (i_cflow_valid) begin
         if (i_cflow_taken)
            r_btb_valid[w_d_idx] <= 1'b1;
         if (i_cflow_is_branch) begin
            if (i_cflow_taken && r_pht[w_d_pidx] != CNT_MAX)
               r_pht[w_d_pidx] <= r_pht[w_d_pidx] + CNT_BITS'(1);
            else if (!i_cflow_taken && r_pht[w_d_pidx] != '0)
               r_pht[w_d_pidx] <= r_pht[w_d_pidx] - CNT_BITS'(1);
            if (HIST_BITS > 0)
               r_ghr <= GHW'({r_ghr, i_cflow_taken});
         end
         // Call+ret on a non-empty stack replaces the top in place, so pointer and count hold.
         if (i_cflow_is_call && (!i_cflow_is_ret || r_ras_cnt == '0)) begin
            r_ras_ptr <= w_ras_next;
            if (r_ras_cnt != RAS_FULL)
               r_ras_cnt <= r_ras_cnt + RCW'(1);
         end else if (i_cflow_is_ret && !i_cflow_is_call && r_ras_cnt != '0) begin
            r_ras_ptr <= w_ras_top;
            r_ras_cnt <= r_ras_cnt - RCW'(1);
         end
      end
   end

   // NOTE: payload arrays carry no reset; valid bits and the RAS count guard them, keeping the clear to one cycle.
   always_ff @(posedge i_clk) begin
      if (w_upd) begin
         if (i_cflow_taken) begin
            r_btb_tag[w_d_idx]    <= i_pc_d[31:IDX+2];
            r_btb_target[w_d_idx] <= i_cflow_target[31:2];
            r_btb_type[w_d_idx]   <= i_cflow_is_branch ? BT_BR : (i_cflow_is_ret ? BT_RET : BT_JMP);
         end
         if (i_cflow_is_call)
            r_ras[w_ras_wr] <= i_pc_d + 32'd4;
      end
   end
endmodule
